// File: rtl/norm_unit_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// norm_unit_arbiter : round-robin share of one normalize unit between two FMA
//                     lanes; operand stage + result stage. Macro NORM_ARB_PERF_EN
//                     adds saturating grant/stall performance counters.
// Revision 1.0
// ---------------------------------------------------------------------------
module norm_unit_arbiter #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  localparam int PW = 3*(SIG_WIDTH+1)+8,
  localparam int NW = SIG_WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [PW-1:0]        req0_prenorm,
  input  logic [5:0]           req0_lza_shamt,
  input  logic [5:0]           req0_shamt,
  input  logic                 req0_cexp_small,
  input  logic [EXP_WIDTH-1:0] req0_res_exp,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [PW-1:0]        req1_prenorm,
  input  logic [5:0]           req1_lza_shamt,
  input  logic [5:0]           req1_shamt,
  input  logic                 req1_cexp_small,
  input  logic [EXP_WIDTH-1:0] req1_res_exp,
  output logic [PW-1:0]        nu_prenorm,
  output logic [5:0]           nu_lza_shamt,
  output logic [5:0]           nu_shamt,
  output logic                 nu_cexp_small,
  output logic [EXP_WIDTH-1:0] nu_res_exp,
  input  logic [NW-1:0]        nu_normalized,
  input  logic [EXP_WIDTH-1:0] nu_exp,
  input  logic                 nu_exp_corr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_tag,
  output logic [NW-1:0]        out_normalized,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_exp_corr
`ifdef NORM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant0,
  output logic [31:0]          perf_grant1,
  output logic [31:0]          perf_stall
`endif
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_tag_q, s1_tag_d;
  logic [PW-1:0]        s1_prenorm_q, s1_prenorm_d;
  logic [5:0]           s1_lza_q, s1_lza_d;
  logic [5:0]           s1_shamt_q, s1_shamt_d;
  logic                 s1_cexp_q, s1_cexp_d;
  logic [EXP_WIDTH-1:0] s1_res_exp_q, s1_res_exp_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_tag_q, out_tag_d;
  logic [NW-1:0]        out_norm_q, out_norm_d;
  logic [EXP_WIDTH-1:0] out_exp_q, out_exp_d;
  logic                 out_corr_q, out_corr_d;
  logic                 adv2, acc1, grant0, grant1, take0, take1;

  always_comb begin
    adv2   = s1_valid_q & (~out_valid_q | out_ready);
    acc1   = ~s1_valid_q | adv2;
    grant0 = req0_valid & (~req1_valid | ~rr_ptr_q);
    grant1 = req1_valid & (~req0_valid | rr_ptr_q);
    // Ready is forced low while reset is asserted, even though acc1 is high then.
    req0_ready = grant0 & acc1 & rst_n;
    req1_ready = grant1 & acc1 & rst_n;
    take0 = req0_valid & req0_ready;
    take1 = req1_valid & req1_ready;

    s1_valid_d   = s1_valid_q;
    s1_tag_d     = s1_tag_q;
    s1_prenorm_d = s1_prenorm_q;
    s1_lza_d     = s1_lza_q;
    s1_shamt_d   = s1_shamt_q;
    s1_cexp_d    = s1_cexp_q;
    s1_res_exp_d = s1_res_exp_q;
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_norm_d   = out_norm_q;
    out_exp_d    = out_exp_q;
    out_corr_d   = out_corr_q;

    if (take0) begin
      s1_valid_d   = 1'b1;
      s1_tag_d     = 1'b0;
      s1_prenorm_d = req0_prenorm;
      s1_lza_d     = req0_lza_shamt;
      s1_shamt_d   = req0_shamt;
      s1_cexp_d    = req0_cexp_small;
      s1_res_exp_d = req0_res_exp;
      rr_ptr_d     = 1'b1;
    end else if (take1) begin
      s1_valid_d   = 1'b1;
      s1_tag_d     = 1'b1;
      s1_prenorm_d = req1_prenorm;
      s1_lza_d     = req1_lza_shamt;
      s1_shamt_d   = req1_shamt;
      s1_cexp_d    = req1_cexp_small;
      s1_res_exp_d = req1_res_exp;
      rr_ptr_d     = 1'b0;
    end else if (acc1) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      out_valid_d = 1'b1;
      out_tag_d   = s1_tag_q;
      out_norm_d  = nu_normalized;
      out_exp_d   = nu_exp;
      out_corr_d  = nu_exp_corr;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= 1'b0;
      s1_prenorm_q <= '0;
      s1_lza_q     <= '0;
      s1_shamt_q   <= '0;
      s1_cexp_q    <= 1'b0;
      s1_res_exp_q <= '0;
      rr_ptr_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= 1'b0;
      out_norm_q   <= '0;
      out_exp_q    <= '0;
      out_corr_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_prenorm_q <= s1_prenorm_d;
      s1_lza_q     <= s1_lza_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_cexp_q    <= s1_cexp_d;
      s1_res_exp_q <= s1_res_exp_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_norm_q   <= out_norm_d;
      out_exp_q    <= out_exp_d;
      out_corr_q   <= out_corr_d;
    end
  end

  assign nu_prenorm     = s1_prenorm_q;
  assign nu_lza_shamt   = s1_lza_q;
  assign nu_shamt       = s1_shamt_q;
  assign nu_cexp_small  = s1_cexp_q;
  assign nu_res_exp     = s1_res_exp_q;
  assign out_valid      = out_valid_q;
  assign out_tag        = out_tag_q;
  assign out_normalized = out_norm_q;
  assign out_exp        = out_exp_q;
  assign out_exp_corr   = out_corr_q;

`ifdef NORM_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_grant0_d = perf_grant0_q;
    perf_grant1_d = perf_grant1_q;
    perf_stall_d  = perf_stall_q;
    if (take0 && (perf_grant0_q != 32'hFFFF_FFFF)) perf_grant0_d = perf_grant0_q + 32'd1;
    if (take1 && (perf_grant1_q != 32'hFFFF_FFFF)) perf_grant1_d = perf_grant1_q + 32'd1;
    if (out_valid_q && !out_ready && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_grant0_q <= perf_grant0_d;
      perf_grant1_q <= perf_grant1_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_norm_unit_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_norm_unit_arbiter : randomized traffic against an occupancy/ordering
//                        scoreboard with a behavioural normalize-unit model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_norm_unit_arbiter;
  localparam int SIG_WIDTH = 23;
  localparam int EXP_WIDTH = 8;
  localparam int PW = 3*(SIG_WIDTH+1)+8;
  localparam int NW = SIG_WIDTH+4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 v   [2];
  logic [PW-1:0]        pre [2];
  logic [5:0]           lza [2];
  logic [5:0]           sh  [2];
  logic                 cs  [2];
  logic [EXP_WIDTH-1:0] re  [2];
  logic                 req0_ready, req1_ready;
  logic [PW-1:0]        nu_prenorm;
  logic [5:0]           nu_lza_shamt, nu_shamt;
  logic                 nu_cexp_small;
  logic [EXP_WIDTH-1:0] nu_res_exp;
  logic [NW-1:0]        nu_normalized;
  logic [EXP_WIDTH-1:0] nu_exp;
  logic                 nu_exp_corr;
  logic                 out_valid, out_ready, out_tag, out_exp_corr;
  logic [NW-1:0]        out_normalized;
  logic [EXP_WIDTH-1:0] out_exp;
`ifdef NORM_ARB_PERF_EN
  logic [31:0]          perf_grant0, perf_grant1, perf_stall;
`endif

  norm_unit_arbiter #(.SIG_WIDTH(SIG_WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_prenorm(pre[0]),
    .req0_lza_shamt(lza[0]), .req0_shamt(sh[0]), .req0_cexp_small(cs[0]), .req0_res_exp(re[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_prenorm(pre[1]),
    .req1_lza_shamt(lza[1]), .req1_shamt(sh[1]), .req1_cexp_small(cs[1]), .req1_res_exp(re[1]),
    .nu_prenorm(nu_prenorm), .nu_lza_shamt(nu_lza_shamt), .nu_shamt(nu_shamt),
    .nu_cexp_small(nu_cexp_small), .nu_res_exp(nu_res_exp),
    .nu_normalized(nu_normalized), .nu_exp(nu_exp), .nu_exp_corr(nu_exp_corr),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_normalized(out_normalized), .out_exp(out_exp), .out_exp_corr(out_exp_corr)
`ifdef NORM_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // Stand-in for the shared normalize unit: shift left by LZA, keep the top NW bits.
  function automatic logic [NW-1:0] norm_f(input logic [PW-1:0] p, input logic [5:0] l);
    logic [PW-1:0] s;
    s = p << l;
    return s[PW-1 -: NW];
  endfunction

  function automatic logic [EXP_WIDTH-1:0] exp_f(input logic [EXP_WIDTH-1:0] e,
                                                 input logic [5:0] l, input logic [5:0] s);
    return e - EXP_WIDTH'(l) + EXP_WIDTH'(s[0]);
  endfunction

  always_comb begin
    nu_normalized = norm_f(nu_prenorm, nu_lza_shamt);
    nu_exp        = exp_f(nu_res_exp, nu_lza_shamt, nu_shamt);
    nu_exp_corr   = nu_cexp_small ^ nu_shamt[5];
  end

  typedef struct packed {
    logic                 tag;
    logic [NW-1:0]        n;
    logic [EXP_WIDTH-1:0] e;
    logic                 c;
    int                   t;
  } item_t;

  item_t q[$];
  logic  rr;
  int    cyc, total, bad, pg0, pg1, pst;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_op(input int n);
    v[n]   = 1'b1;
    pre[n] = {16'($urandom), $urandom, $urandom};
    lza[n] = 6'($urandom);
    sh[n]  = 6'($urandom);
    cs[n]  = 1'($urandom);
    re[n]  = EXP_WIDTH'($urandom);
  endtask

  task automatic refill(input int pct0, input int pct1);
    if (!v[0] && ($urandom_range(99) < pct0)) new_op(0);
    if (!v[1] && ($urandom_range(99) < pct1)) new_op(1);
  endtask

  // One clock: called at the negedge with inputs applied; returns at the next negedge.
  task automatic step();
    logic  acc, g0, g1, eov;
    int    n;
    item_t it;
    #1;
    acc = (q.size() < 2) || out_ready;
    g0  = v[0] && (!v[1] || !rr);
    g1  = v[1] && (!v[0] || rr);
    check_val("req0_ready", req0_ready, g0 && acc);
    check_val("req1_ready", req1_ready, g1 && acc);
    eov = (q.size() > 0) && ((cyc - q[0].t) >= 2);
    check_val("out_valid", out_valid, eov);
    if (eov) begin
      check_val("out_tag", out_tag, q[0].tag);
      check_val("out_normalized", out_normalized, q[0].n);
      check_val("out_exp", out_exp, q[0].e);
      check_val("out_exp_corr", out_exp_corr, q[0].c);
    end
    n = -1;
    @(posedge clk);
    if (eov && out_ready) void'(q.pop_front());
    if (eov && !out_ready) pst++;
    if (acc && (g0 || g1)) begin
      n      = g1 ? 1 : 0;
      it.tag = 1'(n);
      it.n   = norm_f(pre[n], lza[n]);
      it.e   = exp_f(re[n], lza[n], sh[n]);
      it.c   = cs[n] ^ sh[n][5];
      it.t   = cyc;
      q.push_back(it);
      rr = (n == 0);
      if (n == 0) pg0++; else pg1++;
    end
    cyc++;
    @(negedge clk);
    if (n >= 0) v[n] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_req0_ready", req0_ready, 1'b0);
    check_val("rst_req1_ready", req1_ready, 1'b0);
    q.delete();
    rr = 1'b0;
    pg0 = 0; pg1 = 0; pst = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; rr = 1'b0; pg0 = 0; pg1 = 0; pst = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; pre[i] = '0; lza[i] = '0; sh[i] = '0; cs[i] = 1'b0; re[i] = '0;
    end
    v[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_out_valid", out_valid, 1'b0);
    check_val("reset_req0_ready", req0_ready, 1'b0);
    check_val("reset_out_normalized", out_normalized, '0);
    check_val("reset_nu_prenorm", nu_prenorm, '0);
    v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single directed op on req0.
    v[0] = 1'b1; pre[0] = '0; pre[0][77] = 1'b1; lza[0] = 6'd0; sh[0] = 6'd10;
    cs[0] = 1'b0; re[0] = 8'h80;
    repeat (5) step();

    // Both lanes saturated: strict alternation, one result per cycle.
    for (int i = 0; i < 16; i++) begin refill(100, 100); step(); end
    repeat (3) step();

    // Output back-pressure for 5 cycles with both lanes requesting.
    for (int i = 0; i < 12; i++) begin
      refill(100, 100);
      out_ready = !(i >= 3 && i <= 7);
      step();
    end
    out_ready = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (4) step();

    // Only req1, back-to-back.
    for (int i = 0; i < 4; i++) begin refill(0, 100); step(); end
    repeat (4) step();

    // Reset with both stages full, then check the first grant goes to req0.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin refill(100, 100); step(); end
    apply_reset();
    out_ready = 1'b1;
    refill(100, 100);
    step();
    check_val("post_reset_first_tag_req0", 32'(pg0), 32'd1);

    // Random traffic and back-pressure.
    for (int i = 0; i < 400; i++) begin
      refill(50, 50);
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    out_ready = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (4) step();
    check_val("all_results_drained", 32'(q.size()), 32'd0);

`ifdef NORM_ARB_PERF_EN
    #1;
    check_val("perf_grant0", perf_grant0, 32'(pg0));
    check_val("perf_grant1", perf_grant1, 32'(pg1));
    check_val("perf_stall", perf_stall, 32'(pst));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire
